// File: rtl/usb_pkg.sv
// Shared USB definitions.
//  - TX data buffer sizing: depth, pointer width and occupancy width.
//  - tx_packet_t: packet kind requested of usb_tx.
package usb_pkg;

   localparam int unsigned USB_BUF_DEPTH = 64;
   localparam int unsigned USB_BUF_PTR_W = 6;
   localparam int unsigned USB_BUF_OCC_W = 7;

   typedef enum logic [1:0] {
      TX_IDLE      = 2'd0,
      TX_SEND_DATA = 2'd1,
      TX_NAK       = 2'd2,
      TX_ACK       = 2'd3
   } tx_packet_t;

endpackage

// File: rtl/usb_buf_mem.sv
// Byte-wide flop array for the TX data buffer.
// Ports:
//  clk_i        clock, rising edge
//  we_i         write strobe
//  wr_be_i      byte-lane enables; lane k writes wr_data_i[8k+7:8k] to wr_addr_i+k
//  wr_addr_i    base write address; lane addresses wrap modulo Depth
//  wr_data_i    four write byte-lanes, lane 0 in [7:0]
//  rd_addr_i    asynchronous read address
//  rd_data_o    byte at rd_addr_i
module usb_buf_mem
   import usb_pkg::*;
#(
   parameter int unsigned Depth = USB_BUF_DEPTH,
   parameter int unsigned PtrW  = USB_BUF_PTR_W
) (
   input  logic            clk_i,
   input  logic            we_i,
   input  logic [3:0]      wr_be_i,
   input  logic [PtrW-1:0] wr_addr_i,
   input  logic [31:0]     wr_data_i,
   input  logic [PtrW-1:0] rd_addr_i,
   output logic [7:0]      rd_data_o
);

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] lane_addr [4];

   // Pointer-width addition wraps a straddling store from Depth-1 to 0.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = wr_addr_i + PtrW'(k);
      end
   end

   // Contents are not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 4; k++) begin
         if (we_i && wr_be_i[k]) begin
            mem_q[lane_addr[k]] <= wr_data_i[8*k +: 8];
         end
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/usb_tx_data_buffer.sv
// TX-side packet data FIFO feeding usb_tx. The AHB slave pushes 1-4 bytes per store
// (little endian), usb_tx pops one byte per get. The head byte is shown ahead.
// Ports:
//  clk_i                  clock, rising edge
//  n_rst_i                asynchronous active-low reset
//  flush_i                synchronous clear; overrides same-cycle store/get
//  store_tx_data_i        push request
//  store_size_i           bytes to push, 1..4 (other values do nothing)
//  tx_data_i              push data, byte 0 in [7:0] enters first
//  get_tx_packet_data_i   pop request
//  tx_packet_data_o       head byte, 8'h00 when empty
//  buffer_occupancy_o     bytes held, 0..Depth
//  buffer_full_o          occupancy == Depth
//  buffer_empty_o         occupancy == 0
//  overflow_o             one-cycle pulse after a rejected store
//  underflow_o            one-cycle pulse after a get on empty
module usb_tx_data_buffer
   import usb_pkg::*;
#(
   parameter int unsigned Depth = USB_BUF_DEPTH,
   parameter int unsigned PtrW  = USB_BUF_PTR_W,
   parameter int unsigned OccW  = USB_BUF_OCC_W
) (
   input  logic            clk_i,
   input  logic            n_rst_i,
   input  logic            flush_i,
   input  logic            store_tx_data_i,
   input  logic [2:0]      store_size_i,
   input  logic [31:0]     tx_data_i,
   input  logic            get_tx_packet_data_i,
   output logic [7:0]      tx_packet_data_o,
   output logic [OccW-1:0] buffer_occupancy_o,
   output logic            buffer_full_o,
   output logic            buffer_empty_o,
   output logic            overflow_o,
   output logic            underflow_o
);

   localparam logic [OccW-1:0] OccDepth = OccW'(Depth);
   localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0] occ_q, occ_d;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;

   logic            empty;
   logic            size_ok;
   logic            pop;
   logic            push;
   logic [OccW-1:0] occ_eff;
   logic [OccW-1:0] space;
   logic [OccW-1:0] size_occ;
   logic [3:0]      lane_be;
   logic [7:0]      rd_data;

   assign empty    = (occ_q == '0);
   assign size_ok  = (store_size_i != 3'd0) && (store_size_i <= 3'd4);
   assign size_occ = OccW'(store_size_i);

   // A pop in the same cycle frees its slot for the store.
   assign pop     = get_tx_packet_data_i && !empty && !flush_i;
   assign occ_eff = occ_q - OccW'(pop);
   assign space   = OccDepth - occ_eff;
   assign push    = store_tx_data_i && size_ok && (space >= size_occ) && !flush_i;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane_be[k] = (3'(k) < store_size_i);
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(store_size_i);
         end
         occ_d       = occ_eff + (push ? size_occ : '0);
         // Insufficient space drops the whole store; bad sizes are silent no-ops.
         overflow_d  = store_tx_data_i && size_ok && !push;
         underflow_d = get_tx_packet_data_i && empty;
      end
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   usb_buf_mem #(
      .Depth (Depth),
      .PtrW  (PtrW)
   ) u_mem (
      .clk_i     (clk_i),
      .we_i      (push),
      .wr_be_i   (lane_be),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (tx_data_i),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   assign tx_packet_data_o   = empty ? 8'h00 : rd_data;
   assign buffer_occupancy_o = occ_q;
   assign buffer_full_o      = (occ_q == OccDepth);
   assign buffer_empty_o     = empty;
   assign overflow_o         = overflow_q;
   assign underflow_o        = underflow_q;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Bench for usb_tx_data_buffer: directed scenarios plus random traffic, checked against a
// byte-queue model of the FIFO.
module tb_usb_tx_data_buffer;
   import usb_pkg::*;

   localparam int Depth = 64;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        flush;
   logic        store;
   logic [2:0]  size;
   logic [31:0] data;
   logic        get;
   logic [7:0]  tx_byte;
   logic [6:0]  occ;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        unf;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: bytes in FIFO order plus the expected pulses.
   byte unsigned mq[$];
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;

   always #5 clk = ~clk;

   usb_tx_data_buffer u_dut (
      .clk_i                (clk),
      .n_rst_i              (n_rst),
      .flush_i              (flush),
      .store_tx_data_i      (store),
      .store_size_i         (size),
      .tx_data_i            (data),
      .get_tx_packet_data_i (get),
      .tx_packet_data_o     (tx_byte),
      .buffer_occupancy_o   (occ),
      .buffer_full_o        (full),
      .buffer_empty_o       (empty),
      .overflow_o           (ovf),
      .underflow_o          (unf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int unsigned sz;
      sz = mq.size();
      check_eq({tag, "_occ"},   32'(occ),   32'(sz));
      check_eq({tag, "_full"},  32'(full),  32'(sz == Depth));
      check_eq({tag, "_empty"}, 32'(empty), 32'(sz == 0));
      check_eq({tag, "_data"},  32'(tx_byte), (sz > 0) ? 32'(mq[0]) : 32'h0);
      check_eq({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
      check_eq({tag, "_unf"},   32'(unf),   32'(m_unf));
   endtask

   // Drive one cycle of stimulus, advance the model at the edge, then check #1 later.
   task automatic cycle(input string tag, input logic st, input logic [2:0] sz,
                        input logic [31:0] d, input logic g, input logic fl);
      int unsigned n;
      int          room;
      logic        do_pop;
      store = st;
      size  = sz;
      data  = d;
      get   = g;
      flush = fl;
      @(posedge clk);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (fl) begin
         mq.delete();
      end else begin
         n      = 32'(sz);
         do_pop = g && (mq.size() > 0);
         m_unf  = g && (mq.size() == 0);
         if (do_pop) void'(mq.pop_front());
         if (st && n >= 1 && n <= 4) begin
            room = Depth - mq.size();
            if (room >= int'(n)) begin
               for (int k = 0; k < int'(n); k++) mq.push_back(d[8*k +: 8]);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      #1;
      check_all(tag);
      store = 1'b0;
      get   = 1'b0;
      flush = 1'b0;
   endtask

   task automatic async_reset();
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_all("areset");
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst = 1'b0;
      flush = 1'b0;
      store = 1'b0;
      size  = 3'd0;
      data  = 32'h0;
      get   = 1'b0;
      #12;
      check_all("reset");
      @(negedge clk);
      n_rst = 1'b1;

      // 1: idle after reset
      cycle("idle", 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

      // 2: one 4-byte store pops out little endian
      cycle("t2_st", 1'b1, 3'd4, 32'hA5C3_0FF0, 1'b0, 1'b0);
      check_eq("t2_occ4", 32'(occ), 32'd4);
      check_eq("t2_head", 32'(tx_byte), 32'hF0);
      cycle("t2_p0", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t2_b1", 32'(tx_byte), 32'h0F);
      cycle("t2_p1", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t2_b2", 32'(tx_byte), 32'hC3);
      cycle("t2_p2", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t2_b3", 32'(tx_byte), 32'hA5);
      cycle("t2_p3", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t2_empty", 32'(empty), 32'd1);

      // 3: fill, overflow, drain one
      for (int i = 0; i < 16; i++) cycle("t3_fill", 1'b1, 3'd4, $urandom, 1'b0, 1'b0);
      check_eq("t3_full", 32'(full), 32'd1);
      check_eq("t3_occ64", 32'(occ), 32'd64);
      cycle("t3_ovf", 1'b1, 3'd1, 32'h77, 1'b0, 1'b0);
      check_eq("t3_ovf_pulse", 32'(ovf), 32'd1);
      check_eq("t3_occ_keep", 32'(occ), 32'd64);
      cycle("t3_get", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t3_occ63", 32'(occ), 32'd63);
      check_eq("t3_ovf_clear", 32'(ovf), 32'd0);

      // 4: same-cycle pop makes room; without it the store is rejected
      cycle("t4_both", 1'b1, 3'd2, 32'hBEEF, 1'b1, 1'b0);
      check_eq("t4_occ64", 32'(occ), 32'd64);
      check_eq("t4_no_ovf", 32'(ovf), 32'd0);
      cycle("t4_get", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      cycle("t4_rej", 1'b1, 3'd2, 32'hCAFE, 1'b0, 1'b0);
      check_eq("t4_ovf", 32'(ovf), 32'd1);
      check_eq("t4_occ63", 32'(occ), 32'd63);

      // 6: flush overrides store and get, then underflow on empty
      cycle("t6_flush", 1'b1, 3'd4, 32'h1234_5678, 1'b1, 1'b1);
      check_eq("t6_occ0", 32'(occ), 32'd0);
      check_eq("t6_pulses", 32'({ovf, unf}), 32'd0);
      cycle("t6_unf", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t6_unf_pulse", 32'(unf), 32'd1);
      check_eq("t6_data0", 32'(tx_byte), 32'h0);

      // Asynchronous reset with data held
      cycle("pre_rst", 1'b1, 3'd3, 32'h00AB_CDEF, 1'b0, 1'b0);
      async_reset();

      // 5: move both pointers to 62, then straddle the wrap
      for (int i = 0; i < 15; i++) cycle("t5_fill", 1'b1, 3'd4, $urandom, 1'b0, 1'b0);
      cycle("t5_fill2", 1'b1, 3'd2, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 62; i++) cycle("t5_drain", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      cycle("t5_wrap", 1'b1, 3'd4, 32'h4433_2211, 1'b0, 1'b0);
      check_eq("t5_b0", 32'(tx_byte), 32'h11);
      cycle("t5_p0", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t5_b1", 32'(tx_byte), 32'h22);
      cycle("t5_p1", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t5_b2", 32'(tx_byte), 32'h33);
      cycle("t5_p2", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      check_eq("t5_b3", 32'(tx_byte), 32'h44);
      cycle("t5_p3", 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);

      // Random traffic; store bias shifts so occupancy sweeps empty to full
      for (int i = 0; i < 3000; i++) begin
         int unsigned st_pct;
         st_pct = ((i / 300) % 2 == 0) ? 70 : 30;
         cycle("rnd",
               ($urandom_range(99) < st_pct),
               3'($urandom_range(7)),
               $urandom,
               ($urandom_range(99) < 50),
               ($urandom_range(199) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
